// File: rtl/decode_issue.sv
// RV32I decode/issue stage: decodes one fetched instruction per handshake,
// reads regfile operands, and holds the ALU func/operands, control and branch
// target in a single output pipeline entry.
module decode_issue #(
  parameter bit X0_WE_SUPPRESS = 1'b1,
  parameter bit ILLEGAL_AS_NOP = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  alu_func,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  rd_addr,
  output logic        rd_we,
  output logic [2:0]  op_class,
  output logic [2:0]  mem_funct3,
  output logic [31:0] store_data,
  output logic [31:0] br_target,
  output logic        illegal
);

  localparam logic [3:0] F_ADD = 4'd0,  F_LT  = 4'd1,  F_LTU = 4'd2,  F_AND = 4'd3;
  localparam logic [3:0] F_OR  = 4'd4,  F_XOR = 4'd5,  F_SLL = 4'd6,  F_SRL = 4'd7;
  localparam logic [3:0] F_SUB = 4'd8,  F_SRA = 4'd9,  F_EQ  = 4'd10, F_NE  = 4'd11;
  localparam logic [3:0] F_GE  = 4'd12, F_GEU = 4'd13;

  localparam logic [2:0] C_ALU = 3'd0, C_BRANCH = 3'd1, C_JAL = 3'd2;
  localparam logic [2:0] C_JALR = 3'd3, C_LOAD = 3'd4, C_STORE = 3'd5;

  localparam logic [6:0] OPC_OPIMM  = 7'b0010011, OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111, OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011, OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111, OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  // ---- stage p0: combinational decode of the presented instruction ----
  logic [6:0]         opc_p0;
  logic [2:0]         f3_p0;
  logic [6:0]         f7_p0;
  logic signed [31:0] imm_i_p0, imm_s_p0, imm_b_p0, imm_u_p0, imm_j_p0;
  logic [3:0]         func_p0;
  logic [31:0]        a_p0, b_p0, sd_p0, tgt_p0;
  logic               we_p0, ill_p0, accept_p0;
  logic [2:0]         cls_p0;

  // ---- stage p1: output entry registers ----
  logic               vld_p1;
  logic [3:0]         func_p1;
  logic [31:0]        a_p1, b_p1, sd_p1, tgt_p1;
  logic [4:0]         rd_p1;
  logic               we_p1, ill_p1;
  logic [2:0]         cls_p1, f3_p1;

  assign opc_p0   = in_instr[6:0];
  assign f3_p0    = in_instr[14:12];
  assign f7_p0    = in_instr[31:25];
  assign rs1_addr = in_instr[19:15];
  assign rs2_addr = in_instr[24:20];

  assign imm_i_p0 = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s_p0 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b_p0 = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                     in_instr[11:8], 1'b0};
  assign imm_u_p0 = {in_instr[31:12], 12'b0};
  assign imm_j_p0 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                     in_instr[30:21], 1'b0};

  // A new entry may load when the slot is empty or is being consumed.
  assign in_ready  = !vld_p1 || out_ready;
  assign accept_p0 = in_valid && in_ready && !flush;

  // Maps the shared OP/OP-IMM funct3 encoding onto an ALU func code.
  function automatic logic [3:0] alu_of_f3(input logic [2:0] f3, input logic alt);
    logic [3:0] f;
    case (f3)
      3'b000:  f = F_ADD;
      3'b001:  f = F_SLL;
      3'b010:  f = F_LT;
      3'b011:  f = F_LTU;
      3'b100:  f = F_XOR;
      3'b101:  f = alt ? F_SRA : F_SRL;
      3'b110:  f = F_OR;
      default: f = F_AND;
    endcase
    return f;
  endfunction

  // Decode opcode/funct fields into func, operands, class and target.
  always_comb begin
    func_p0 = F_ADD;
    a_p0    = '0;
    b_p0    = '0;
    sd_p0   = '0;
    tgt_p0  = '0;
    we_p0   = 1'b0;
    ill_p0  = 1'b0;
    cls_p0  = C_ALU;
    case (opc_p0)
      OPC_OPIMM: begin
        a_p0  = rs1_data;
        we_p0 = 1'b1;
        if (f3_p0 == 3'b001 || f3_p0 == 3'b101) begin
          b_p0    = {27'b0, in_instr[24:20]};
          func_p0 = alu_of_f3(f3_p0, in_instr[30]);
          if (f3_p0 == 3'b001) ill_p0 = (f7_p0 != 7'b0000000);
          else                 ill_p0 = (f7_p0 != 7'b0000000) && (f7_p0 != 7'b0100000);
        end else begin
          b_p0    = imm_i_p0;
          func_p0 = alu_of_f3(f3_p0, 1'b0);
        end
      end
      OPC_OP: begin
        a_p0    = rs1_data;
        b_p0    = rs2_data;
        we_p0   = 1'b1;
        func_p0 = (f3_p0 == 3'b000) ? (in_instr[30] ? F_SUB : F_ADD)
                                    : alu_of_f3(f3_p0, in_instr[30]);
        ill_p0  = !((f7_p0 == 7'b0000000) ||
                    (f7_p0 == 7'b0100000 && (f3_p0 == 3'b000 || f3_p0 == 3'b101)));
      end
      OPC_LUI: begin
        b_p0  = imm_u_p0;
        we_p0 = 1'b1;
      end
      OPC_AUIPC: begin
        a_p0  = in_pc;
        b_p0  = imm_u_p0;
        we_p0 = 1'b1;
      end
      OPC_BRANCH: begin
        cls_p0 = C_BRANCH;
        a_p0   = rs1_data;
        b_p0   = rs2_data;
        tgt_p0 = 32'($signed(in_pc) + imm_b_p0);
        case (f3_p0)
          3'b000:  func_p0 = F_EQ;
          3'b001:  func_p0 = F_NE;
          3'b100:  func_p0 = F_LT;
          3'b101:  func_p0 = F_GE;
          3'b110:  func_p0 = F_LTU;
          3'b111:  func_p0 = F_GEU;
          default: ill_p0  = 1'b1;
        endcase
      end
      OPC_JAL: begin
        cls_p0 = C_JAL;
        a_p0   = in_pc;
        b_p0   = 32'd4;
        we_p0  = 1'b1;
        tgt_p0 = 32'($signed(in_pc) + imm_j_p0);
      end
      OPC_JALR: begin
        cls_p0 = C_JALR;
        a_p0   = in_pc;
        b_p0   = 32'd4;
        we_p0  = 1'b1;
        tgt_p0 = 32'($signed(rs1_data) + imm_i_p0) & ~32'd1;
      end
      OPC_LOAD: begin
        cls_p0 = C_LOAD;
        a_p0   = rs1_data;
        b_p0   = imm_i_p0;
        we_p0  = 1'b1;
      end
      OPC_STORE: begin
        cls_p0 = C_STORE;
        a_p0   = rs1_data;
        b_p0   = imm_s_p0;
        sd_p0  = rs2_data;
      end
      default: ill_p0 = 1'b1;
    endcase
    // Illegal words still issue, but as a harmless non-writing ADD 0+0.
    if (ill_p0 && ILLEGAL_AS_NOP) begin
      func_p0 = F_ADD;
      a_p0    = '0;
      b_p0    = '0;
      sd_p0   = '0;
      tgt_p0  = '0;
      cls_p0  = C_ALU;
    end
    if (ill_p0) we_p0 = 1'b0;
    if (X0_WE_SUPPRESS && in_instr[11:7] == 5'd0) we_p0 = 1'b0;
  end

  // Output entry: load on accept, drop on consume/flush, otherwise hold.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      vld_p1  <= 1'b0;
      func_p1 <= '0;
      a_p1    <= '0;
      b_p1    <= '0;
      rd_p1   <= '0;
      we_p1   <= 1'b0;
      cls_p1  <= '0;
      f3_p1   <= '0;
      sd_p1   <= '0;
      tgt_p1  <= '0;
      ill_p1  <= 1'b0;
    end else if (accept_p0) begin
      vld_p1  <= 1'b1;
      func_p1 <= func_p0;
      a_p1    <= a_p0;
      b_p1    <= b_p0;
      rd_p1   <= in_instr[11:7];
      we_p1   <= we_p0;
      cls_p1  <= cls_p0;
      f3_p1   <= f3_p0;
      sd_p1   <= sd_p0;
      tgt_p1  <= tgt_p0;
      ill_p1  <= ill_p0;
    end else if (out_ready || flush) begin
      vld_p1  <= 1'b0;
    end
  end

  assign out_valid  = vld_p1;
  assign alu_func   = func_p1;
  assign alu_a      = a_p1;
  assign alu_b      = b_p1;
  assign rd_addr    = rd_p1;
  assign rd_we      = we_p1;
  assign op_class   = cls_p1;
  assign mem_funct3 = f3_p1;
  assign store_data = sd_p1;
  assign br_target  = tgt_p1;
  assign illegal    = ill_p1;

endmodule

// File: tb/tb_decode_issue.sv
// Bench for decode_issue: directed literal cases plus a randomized run checked
// every cycle against a behavioural model of the output entry.
module tb_decode_issue;

  logic        clock = 1'b0;
  logic        reset_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, rs1_data, rs2_data;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic [3:0]  alu_func;
  logic [31:0] alu_a, alu_b, store_data, br_target;
  logic        rd_we, illegal;
  logic [2:0]  op_class, mem_funct3;

  logic [31:0] regs [32];
  assign rs1_data = regs[in_instr[19:15]];
  assign rs2_data = regs[in_instr[24:20]];

  decode_issue dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .out_valid(out_valid), .out_ready(out_ready), .alu_func(alu_func),
    .alu_a(alu_a), .alu_b(alu_b), .rd_addr(rd_addr), .rd_we(rd_we),
    .op_class(op_class), .mem_funct3(mem_funct3), .store_data(store_data),
    .br_target(br_target), .illegal(illegal)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0]  func;
    logic [31:0] a, b;
    logic [4:0]  rd;
    logic        we;
    logic [2:0]  cls, f3;
    logic [31:0] sd, tgt;
    logic        ill;
  } ent_t;

  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;
  logic m_valid = 1'b0;
  ent_t m_e = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // ALU func for the register/immediate arithmetic group, by funct3.
  function automatic logic [3:0] arith_func(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0: return 4'd0;
      3'd1: return 4'd6;
      3'd2: return 4'd1;
      3'd3: return 4'd2;
      3'd4: return 4'd5;
      3'd5: return alt ? 4'd9 : 4'd7;
      3'd6: return 4'd4;
      default: return 4'd3;
    endcase
  endfunction

  // Reference decode: what the issued entry must hold for one instruction.
  function automatic ent_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                      input logic [31:0] r1, input logic [31:0] r2);
    ent_t e;
    int imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [2:0] f3;
    logic [6:0] f7;
    f3    = ins[14:12];
    f7    = ins[31:25];
    imm_i = int'($signed(ins[31:20]));
    imm_s = int'($signed({ins[31:25], ins[11:7]}));
    imm_b = int'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
    imm_u = int'({ins[31:12], 12'h000});
    imm_j = int'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
    e = '0;
    e.rd = ins[11:7];
    e.f3 = f3;
    case (ins[6:0])
      7'h13: begin
        e.a = r1; e.we = 1;
        if (f3 == 1 || f3 == 5) begin
          e.b = 32'(ins[24:20]);
          e.func = arith_func(f3, ins[30]);
          e.ill = (f3 == 1) ? (f7 != 0) : !(f7 == 0 || f7 == 7'h20);
        end else begin
          e.b = imm_i; e.func = arith_func(f3, 1'b0);
        end
      end
      7'h33: begin
        e.a = r1; e.b = r2; e.we = 1;
        e.func = (f3 == 0 && ins[30]) ? 4'd8 : arith_func(f3, ins[30]);
        e.ill = !(f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5)));
      end
      7'h37: begin e.b = imm_u; e.we = 1; end
      7'h17: begin e.a = pc; e.b = imm_u; e.we = 1; end
      7'h63: begin
        e.cls = 1; e.a = r1; e.b = r2; e.tgt = pc + imm_b;
        case (f3)
          3'd0: e.func = 10;
          3'd1: e.func = 11;
          3'd4: e.func = 1;
          3'd5: e.func = 12;
          3'd6: e.func = 2;
          3'd7: e.func = 13;
          default: e.ill = 1;
        endcase
      end
      7'h6F: begin e.cls = 2; e.a = pc; e.b = 4; e.we = 1; e.tgt = pc + imm_j; end
      7'h67: begin e.cls = 3; e.a = pc; e.b = 4; e.we = 1; e.tgt = (r1 + imm_i) & 32'hFFFF_FFFE; end
      7'h03: begin e.cls = 4; e.a = r1; e.b = imm_i; e.we = 1; end
      7'h23: begin e.cls = 5; e.a = r1; e.b = imm_s; e.sd = r2; end
      default: e.ill = 1;
    endcase
    if (e.ill) begin
      e.func = 0; e.a = 0; e.b = 0; e.sd = 0; e.tgt = 0; e.cls = 0; e.we = 0;
    end
    if (e.rd == 0) e.we = 0;
    return e;
  endfunction

  // Model of the single output slot.
  always @(posedge clock) begin
    if (!reset_n) begin
      m_valid <= 1'b0;
      m_e     <= '0;
    end else if (in_valid && (!m_valid || out_ready) && !flush) begin
      m_valid <= 1'b1;
      m_e     <= ref_decode(in_instr, in_pc, rs1_data, rs2_data);
    end else if (out_ready || flush) begin
      m_valid <= 1'b0;
    end
  end

  // Every-cycle comparison of DUT against the model.
  always @(negedge clock) begin
    if (chk_en) begin
      chk("in_ready", in_ready, !m_valid || out_ready);
      chk("rs1_addr", rs1_addr, in_instr[19:15]);
      chk("rs2_addr", rs2_addr, in_instr[24:20]);
      chk("out_valid", out_valid, m_valid);
      chk("alu_func", alu_func, m_e.func);
      chk("alu_a", alu_a, m_e.a);
      chk("alu_b", alu_b, m_e.b);
      chk("rd_addr", rd_addr, m_e.rd);
      chk("rd_we", rd_we, m_e.we);
      chk("op_class", op_class, m_e.cls);
      chk("mem_funct3", mem_funct3, m_e.f3);
      chk("store_data", store_data, m_e.sd);
      chk("br_target", br_target, m_e.tgt);
      chk("illegal", illegal, m_e.ill);
    end
  end

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0]  opcs [10];
    opcs = '{7'h13, 7'h33, 7'h37, 7'h17, 7'h63, 7'h6F, 7'h67, 7'h03, 7'h23, 7'h13};
    w = $urandom;
    if ($urandom_range(0, 15) != 0) begin
      w[6:0] = opcs[$urandom_range(0, 9)];
      if ((w[6:0] == 7'h13 || w[6:0] == 7'h33) && $urandom_range(0, 3) != 0)
        w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
    end
    return w;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    regs[0] = 32'd0;
    for (int i = 1; i < 32; i++) regs[i] = $urandom;
    reset_n = 0; flush = 0; in_valid = 1; out_ready = 0;
    in_instr = 32'hFFD0_8293; in_pc = 32'h0;
    step();
    chk_en = 1'b1;
    step();
    chk("rst out_valid", out_valid, 0);
    chk("rst in_ready", in_ready, 1);
    chk("rst alu_a", alu_a, 0);
    chk("rst rd_we", rd_we, 0);

    // addi x5,x1,-3
    reset_n = 1; out_ready = 1; regs[1] = 32'd10;
    step();
    chk("addi out_valid", out_valid, 1);
    chk("addi func", alu_func, 0);
    chk("addi a", alu_a, 32'd10);
    chk("addi b", alu_b, 32'hFFFF_FFFD);
    chk("addi rd", rd_addr, 5);
    chk("addi rd_we", rd_we, 1);

    // sub x3,x1,x2 then srai x4,x1,4
    regs[1] = 32'd7; regs[2] = 32'd9; in_instr = 32'h4020_81B3;
    step();
    chk("sub func", alu_func, 8);
    chk("sub a", alu_a, 7);
    chk("sub b", alu_b, 9);
    in_instr = 32'h4040_D213;
    step();
    chk("srai func", alu_func, 9);
    chk("srai b", alu_b, 4);

    // bge x1,x2,+16 at pc 0x100
    in_instr = 32'h0020_D863; in_pc = 32'h100;
    step();
    chk("bge func", alu_func, 12);
    chk("bge class", op_class, 1);
    chk("bge target", br_target, 32'h110);
    chk("bge rd_we", rd_we, 0);

    // stall three cycles with addi x6,x0,1 waiting
    out_ready = 0; in_instr = 32'h0010_0313; in_pc = 32'h104;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall in_ready", in_ready, 0);
      step();
      chk("stall out_valid", out_valid, 1);
      chk("stall func", alu_func, 12);
      chk("stall target", br_target, 32'h110);
    end
    out_ready = 1;
    #1;
    chk("release in_ready", in_ready, 1);
    step();
    chk("release rd", rd_addr, 6);
    chk("release b", alu_b, 1);
    chk("release func", alu_func, 0);

    // flush coincident with accept, then an all-ones illegal word
    flush = 1; in_instr = 32'hFFFF_FFFF;
    #1;
    chk("flush in_ready", in_ready, 1);
    step();
    chk("flush out_valid", out_valid, 0);
    flush = 0;
    step();
    chk("ill out_valid", out_valid, 1);
    chk("ill flag", illegal, 1);
    chk("ill rd_we", rd_we, 0);
    chk("ill a", alu_a, 0);
    chk("ill b", alu_b, 0);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      reset_n   = ($urandom_range(0, 249) != 0);
      in_instr  = rand_instr();
      in_pc     = $urandom;
      regs[$urandom_range(1, 31)] = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
